// File: rtl/mem_stage.sv
// MEM stage: 256x32 data RAM with byte/half/word stores on the rising edge and combinational, sign/zero-extended loads.
// Latency: stores take one edge, loads are zero-cycle; there is no handshake and an access may issue every cycle.
module mem_stage #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [31:0] ALUOut,
   input  logic [31:0] MemoryWriteData,
   input  logic [31:0] Controls,
   output logic [31:0] out_MemoryData
);

   logic [31:0]   mem [DEPTH];

   logic          mem_write;
   logic          mem_read;
   logic [1:0]    size;
   logic          load_signed;
   logic [AW-1:0] idx;
   logic [1:0]    lane;

   assign mem_write   = Controls[0];
   assign mem_read    = Controls[1];
   assign size        = Controls[3:2];
   assign load_signed = Controls[4];
   assign idx         = ALUOut[AW+1:2];
   assign lane        = ALUOut[1:0];

   // High address bits and upper control bits are intentionally dropped.
   logic unused_bits;
   assign unused_bits = ^{Controls[31:5], ALUOut[31:AW+2]};

   logic [3:0]  wr_mask;
   logic [31:0] wr_data;

   always_comb begin
      wr_mask = 4'b1111;
      wr_data = MemoryWriteData;
      case (size)
         2'b01: begin
            wr_mask = lane[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{MemoryWriteData[15:0]}};
         end
         2'b10: begin
            wr_mask = 4'b0001 << lane;
            wr_data = {4{MemoryWriteData[7:0]}};
         end
         default: begin
            wr_mask = 4'b1111;
            wr_data = MemoryWriteData;
         end
      endcase
   end

   // Reset clears the whole array and takes priority over a store on the same edge.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (mem_write) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_mask[b]) begin
               mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   logic [31:0] rd_word;
   logic [15:0] rd_half;
   logic [7:0]  rd_byte;

   always_comb begin
      rd_word = mem[idx];
      rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
      case (lane)
         2'd0:    rd_byte = rd_word[7:0];
         2'd1:    rd_byte = rd_word[15:8];
         2'd2:    rd_byte = rd_word[23:16];
         default: rd_byte = rd_word[31:24];
      endcase
   end

   always_comb begin
      out_MemoryData = '0;
      if (!Rst && mem_read) begin
         case (size)
            2'b01:   out_MemoryData = {{16{load_signed & rd_half[15]}}, rd_half};
            2'b10:   out_MemoryData = {{24{load_signed & rd_byte[7]}}, rd_byte};
            default: out_MemoryData = rd_word;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stores and loads of every size with hand-computed results.
module tb_mem_stage;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic [31:0] ALUOut = '0;
   logic [31:0] MemoryWriteData = '0;
   logic [31:0] Controls = '0;
   logic [31:0] out_MemoryData;

   int checks = 0;
   int errors = 0;

   mem_stage #(.DEPTH(256), .AW(8)) dut (
      .Clk(Clk),
      .Rst(Rst),
      .ALUOut(ALUOut),
      .MemoryWriteData(MemoryWriteData),
      .Controls(Controls),
      .out_MemoryData(out_MemoryData)
   );

   always #5 Clk = ~Clk;

   // Control words: bit0 write, bit1 read, [3:2] size, bit4 signed
   localparam logic [31:0] C_WR_W  = 32'h01;
   localparam logic [31:0] C_WR_H  = 32'h05;
   localparam logic [31:0] C_WR_B  = 32'h09;
   localparam logic [31:0] C_RD_W  = 32'h02;
   localparam logic [31:0] C_RD_HU = 32'h06;
   localparam logic [31:0] C_RD_HS = 32'h16;
   localparam logic [31:0] C_RD_BU = 32'h0A;
   localparam logic [31:0] C_RD_BS = 32'h1A;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] expected);
      #1;
      checks++;
      assert (out_MemoryData === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, out_MemoryData, expected);
      end
   endtask

   task automatic store(input logic [31:0] ctl, input logic [31:0] addr, input logic [31:0] data);
      Controls = ctl;
      ALUOut = addr;
      MemoryWriteData = data;
      tick();
      Controls = '0;
   endtask

   task automatic load(input logic [31:0] ctl, input logic [31:0] addr);
      Controls = ctl;
      ALUOut = addr;
   endtask

   initial begin
      // Reset pulse; output forced low while Rst is high
      Rst = 1'b1;
      load(C_RD_W, 32'h40);
      check("rst_force_zero", 32'h0);
      tick();
      Rst = 1'b0;
      check("post_rst_read_40", 32'h0);
      load(C_RD_W, 32'h3FC);
      check("post_rst_read_3fc", 32'h0);

      // All-ones control word: word store with read, misaligned address ignored
      Controls = 32'hFFFF_FFFF;
      ALUOut = 32'h1;
      MemoryWriteData = 32'd10;
      check("rw_pre_edge", 32'h0);
      tick();
      check("rw_post_edge", 32'h0000_000A);
      load(32'h0, 32'h0);
      check("read_disabled", 32'h0);
      load(C_RD_W, 32'h0);
      check("word0", 32'h0000_000A);

      // Byte loads from a stored word
      store(C_WR_W, 32'h10, 32'h80FF_7F01);
      load(C_RD_BU, 32'h10); check("bu_lane0", 32'h0000_0001);
      load(C_RD_BU, 32'h11); check("bu_lane1", 32'h0000_007F);
      load(C_RD_BU, 32'h12); check("bu_lane2", 32'h0000_00FF);
      load(C_RD_BU, 32'h13); check("bu_lane3", 32'h0000_0080);
      load(C_RD_BS, 32'h10); check("bs_lane0", 32'h0000_0001);
      load(C_RD_BS, 32'h11); check("bs_lane1", 32'h0000_007F);
      load(C_RD_BS, 32'h12); check("bs_lane2", 32'hFFFF_FFFF);
      load(C_RD_BS, 32'h13); check("bs_lane3", 32'hFFFF_FF80);

      // Byte store into lane 3 leaves other lanes alone
      store(C_WR_B, 32'h13, 32'h1234_56AA);
      load(C_RD_W, 32'h10); check("byte_store_lane3", 32'hAAFF_7F01);
      store(C_WR_B, 32'h11, 32'hFFFF_FF22);
      load(C_RD_W, 32'h10); check("byte_store_lane1", 32'hAAFF_2201);

      // Halfword store over a word
      store(C_WR_W, 32'h20, 32'h1122_3344);
      store(C_WR_H, 32'h22, 32'h1234_BEEF);
      load(C_RD_W, 32'h20);  check("half_store_word", 32'hBEEF_3344);
      load(C_RD_HS, 32'h22); check("hs_upper", 32'hFFFF_BEEF);
      load(C_RD_HU, 32'h22); check("hu_upper", 32'h0000_BEEF);
      load(C_RD_HU, 32'h23); check("hu_upper_odd", 32'h0000_BEEF);
      load(C_RD_HS, 32'h20); check("hs_lower", 32'h0000_3344);
      store(C_WR_H, 32'h21, 32'h0000_8001);
      load(C_RD_W, 32'h20);  check("half_store_lower", 32'hBEEF_8001);

      // Address wrap modulo 1 KiB
      store(C_WR_W, 32'h400, 32'h1234_5678);
      load(C_RD_W, 32'h000);      check("wrap_read_0", 32'h1234_5678);
      load(C_RD_W, 32'hFFFF_FC00); check("wrap_read_high", 32'h1234_5678);

      // Reset wins over a store on the same edge
      store(C_WR_W, 32'h8, 32'h0000_0055);
      load(C_RD_W, 32'h8); check("pre_rst_word8", 32'h0000_0055);
      Rst = 1'b1;
      Controls = 32'h3;
      ALUOut = 32'h8;
      MemoryWriteData = 32'hDEAD_BEEF;
      check("rst_hold_pre_edge", 32'h0);
      tick();
      check("rst_hold_post_edge", 32'h0);
      Rst = 1'b0;
      load(C_RD_W, 32'h8);  check("rst_cleared_word8", 32'h0);
      load(C_RD_W, 32'h10); check("rst_cleared_word10", 32'h0);
      load(C_RD_W, 32'h0);  check("rst_cleared_word0", 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
